// File: rtl/sid_voice_bank.sv
// sid_voice_bank: time-multiplexed tone generator, one voice per enabled slot, mixed into a volume-scaled sample.
// Define SID_VOICE_NOISE_EN to give each voice a 15-bit noise LFSR (wave select 11).
module sid_voice_bank #(
    parameter int VOICES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  addr,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    input  logic        bus_cyc,
    input  logic        bus_we,
    output logic [14:0] sample_out,
    output logic        sample_ready
);
    logic [23:0] r_freq    [VOICES];
    logic [11:0] r_pw      [VOICES];
    logic [7:0]  r_ctrl    [VOICES];
    logic [7:0]  r_rate    [VOICES];
    logic [7:0]  r_level   [VOICES];
    logic [7:0]  r_ratectr [VOICES];
    logic [23:0] r_acc     [VOICES];
`ifdef SID_VOICE_NOISE_EN
    logic [14:0] r_lfsr    [VOICES];
    logic [14:0] w_lfsr;
    logic [14:0] w_lfsrNext;
`endif
    logic [3:0]  r_vol;
    logic [1:0]  r_clkTrg;
    logic [1:0]  r_ctr;
    logic [2:0]  r_slot;
    logic [14:0] r_mix;
    logic [7:0]  r_busOut;
    logic [14:0] r_sampleOut;
    logic        r_sampleReady;

    logic        w_en;
    logic        w_isVoiceSlot;
    logic        w_write;
    logic [23:0] w_acc;
    logic [23:0] w_freq;
    logic [23:0] w_accNext;
    logic [11:0] w_pw;
    logic [11:0] w_top;
    logic [11:0] w_wave;
    logic [7:0]  w_rate;
    logic [7:0]  w_level;
    logic [7:0]  w_ratectr;
    logic [7:0]  w_levelNext;
    logic [7:0]  w_ratectrNext;
    logic [7:0]  w_rdData;
    logic        w_gate;
    logic        w_test;
    logic        w_step;
    logic [1:0]  w_waveSel;
    logic [11:0] w_contrib;
    logic [14:0] w_sample;

    assign w_en          = (r_clkTrg == 2'd0) || (r_ctr == r_clkTrg);
    assign w_isVoiceSlot = r_slot < 3'(VOICES);
    assign w_write       = bus_cyc && bus_we;
    assign w_sample      = 15'(({4'd0, r_mix} * {15'd0, r_vol}) >> 4);

    // Select the state of the voice owned by the current slot.
    always_comb begin
        w_acc     = '0;
        w_freq    = '0;
        w_pw      = '0;
        w_rate    = '0;
        w_level   = '0;
        w_ratectr = '0;
        w_gate    = 1'b0;
        w_test    = 1'b0;
        w_waveSel = '0;
`ifdef SID_VOICE_NOISE_EN
        w_lfsr    = '0;
`endif
        for (int v = 0; v < VOICES; v++) begin
            if (r_slot == 3'(v)) begin
                w_acc     = r_acc[v];
                w_freq    = r_freq[v];
                w_pw      = r_pw[v];
                w_rate    = r_rate[v];
                w_level   = r_level[v];
                w_ratectr = r_ratectr[v];
                w_gate    = r_ctrl[v][0];
                w_waveSel = r_ctrl[v][3:2];
                w_test    = r_ctrl[v][4];
`ifdef SID_VOICE_NOISE_EN
                w_lfsr    = r_lfsr[v];
`endif
            end
        end
    end

    always_comb begin
        w_accNext = w_test ? 24'd0 : w_acc + w_freq;
        w_top     = w_accNext[23:12];
        w_wave    = 12'h000;
        case (w_waveSel)
            2'b00:   w_wave = w_top;
            2'b01:   w_wave = {w_top[10:0] ^ {11{w_top[11]}}, 1'b0};
            2'b10:   w_wave = (w_top >= w_pw) ? 12'hFFF : 12'h000;
            default: begin
`ifdef SID_VOICE_NOISE_EN
                w_wave = {w_lfsr[14:4], 1'b0};
`else
                w_wave = 12'h000;
`endif
            end
        endcase
`ifdef SID_VOICE_NOISE_EN
        w_lfsrNext = w_lfsr;
        if (w_test) begin
            w_lfsrNext = 15'h7FFF;
        end else if (!w_acc[19] && w_accNext[19]) begin
            w_lfsrNext = {w_lfsr[13:0], w_lfsr[14] ^ w_lfsr[13]};
        end
`endif
        // Envelope steps when the rate counter reaches rate; the mix uses the pre-step level.
        w_step        = (w_ratectr == w_rate);
        w_ratectrNext = w_step ? 8'd0 : w_ratectr + 8'd1;
        w_levelNext   = w_level;
        if (w_step) begin
            if (w_gate) begin
                if (w_level != 8'hFF) w_levelNext = w_level + 8'd1;
            end else if (w_level != 8'h00) begin
                w_levelNext = w_level - 8'd1;
            end
        end
        w_contrib = 12'(({8'd0, w_wave} * {12'd0, w_level}) >> 8);
    end

    always_comb begin
        w_rdData = 8'h00;
        case (addr)
            6'd56:   w_rdData = {4'd0, r_vol};
            6'd57:   w_rdData = {6'd0, r_clkTrg};
            6'd59:   w_rdData = {5'b10100, 3'(VOICES)};
            default: w_rdData = 8'h00;
        endcase
        for (int v = 0; v < VOICES; v++) begin
            if (addr[5:3] == 3'(v)) begin
                case (addr[2:0])
                    3'd0:    w_rdData = r_freq[v][7:0];
                    3'd1:    w_rdData = r_freq[v][15:8];
                    3'd2:    w_rdData = r_freq[v][23:16];
                    3'd3:    w_rdData = r_pw[v][7:0];
                    3'd4:    w_rdData = {4'd0, r_pw[v][11:8]};
                    3'd5:    w_rdData = r_ctrl[v];
                    3'd6:    w_rdData = r_rate[v];
                    default: w_rdData = r_level[v];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++) begin
                r_freq[v]    <= '0;
                r_pw[v]      <= 12'h800;
                r_ctrl[v]    <= '0;
                r_rate[v]    <= '0;
                r_level[v]   <= '0;
                r_ratectr[v] <= '0;
                r_acc[v]     <= '0;
`ifdef SID_VOICE_NOISE_EN
                r_lfsr[v]    <= 15'h7FFF;
`endif
            end
            r_vol         <= '0;
            r_clkTrg      <= '0;
            r_ctr         <= '0;
            r_slot        <= '0;
            r_mix         <= '0;
            r_busOut      <= '0;
            r_sampleOut   <= '0;
            r_sampleReady <= 1'b0;
        end else begin
            r_sampleReady <= 1'b0;
            if (bus_cyc) r_busOut <= w_rdData;
            if (w_write && addr == 6'd56) r_vol <= bus_in[3:0];
            if (w_write && addr == 6'd57) r_clkTrg <= bus_in[1:0];
            r_ctr <= w_en ? 2'd0 : r_ctr + 2'd1;
            if (w_en) begin
                if (w_isVoiceSlot) begin
                    r_slot <= r_slot + 3'd1;
                    r_mix  <= r_mix + {3'd0, w_contrib};
                end else begin
                    r_slot        <= 3'd0;
                    r_mix         <= '0;
                    r_sampleOut   <= w_sample;
                    r_sampleReady <= 1'b1;
                end
            end
            for (int v = 0; v < VOICES; v++) begin
                if (w_write && addr[5:3] == 3'(v)) begin
                    case (addr[2:0])
                        3'd0:    r_freq[v][7:0]   <= bus_in;
                        3'd1:    r_freq[v][15:8]  <= bus_in;
                        3'd2:    r_freq[v][23:16] <= bus_in;
                        3'd3:    r_pw[v][7:0]     <= bus_in;
                        3'd4:    r_pw[v][11:8]    <= bus_in[3:0];
                        3'd5:    r_ctrl[v]        <= bus_in;
                        3'd6:    r_rate[v]        <= bus_in;
                        default: ;
                    endcase
                end
                if (w_en && r_slot == 3'(v)) begin
                    r_acc[v]     <= w_accNext;
                    r_level[v]   <= w_levelNext;
                    r_ratectr[v] <= w_ratectrNext;
`ifdef SID_VOICE_NOISE_EN
                    r_lfsr[v]    <= w_lfsrNext;
`endif
                end
            end
        end
    end

    assign bus_out      = r_busOut;
    assign sample_out   = r_sampleOut;
    assign sample_ready = r_sampleReady;
endmodule

// File: tb/tb_sid_voice_bank.sv
// tb_sid_voice_bank: random bus traffic against a frame-arithmetic reference model with a sample/read scoreboard.
module tb_sid_voice_bank;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  addr = '0;
    logic [7:0]  bus_in = '0;
    logic [7:0]  bus_out;
    logic        bus_cyc = 1'b0;
    logic        bus_we = 1'b0;
    logic [14:0] sample_out;
    logic        sample_ready;

    sid_voice_bank #(.VOICES(V)) dut (
        .clk(clk), .rst(rst), .addr(addr), .bus_in(bus_in), .bus_out(bus_out),
        .bus_cyc(bus_cyc), .bus_we(bus_we), .sample_out(sample_out), .sample_ready(sample_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int expSample[$];
    int expRead[$];
    bit checkSamples = 1'b0;
    bit rdValid = 1'b0;

    // Reference model state, advanced one clock at a time in lockstep with the stimulus
    int unsigned mFreq[V], mPw[V], mCtrl[V], mRate[V], mLevel[V], mRatectr[V], mAcc[V], mLfsr[V];
    int unsigned mVol, mMix;
    int cycleN;

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== 32'(expected)) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    function automatic void modelReset();
        for (int v = 0; v < V; v++) begin
            mFreq[v] = 0; mPw[v] = 32'h800; mCtrl[v] = 0; mRate[v] = 0;
            mLevel[v] = 0; mRatectr[v] = 0; mAcc[v] = 0; mLfsr[v] = 32'h7FFF;
        end
        mVol = 0; mMix = 0; cycleN = 0;
    endfunction

    function automatic int readModel(input int a);
        int v, r;
        if (a < V * 8) begin
            v = a / 8; r = a % 8;
            case (r)
                0: return int'(mFreq[v] & 255);
                1: return int'((mFreq[v] >> 8) & 255);
                2: return int'((mFreq[v] >> 16) & 255);
                3: return int'(mPw[v] & 255);
                4: return int'(mPw[v] >> 8);
                5: return int'(mCtrl[v]);
                6: return int'(mRate[v]);
                default: return int'(mLevel[v]);
            endcase
        end
        if (a == 56) return int'(mVol);
        if (a == 59) return 32'hA0 + V;
        return 0;
    endfunction

    function automatic void writeModel(input int a, input int d);
        int v, r;
        if (a < V * 8) begin
            v = a / 8; r = a % 8;
            case (r)
                0: mFreq[v] = (mFreq[v] & 32'hFFFF00) | d;
                1: mFreq[v] = (mFreq[v] & 32'hFF00FF) | (d << 8);
                2: mFreq[v] = (mFreq[v] & 32'h00FFFF) | (d << 16);
                3: mPw[v] = (mPw[v] & 32'hF00) | d;
                4: mPw[v] = (mPw[v] & 32'h0FF) | ((d & 15) << 8);
                5: mCtrl[v] = d;
                6: mRate[v] = d;
                default: ;
            endcase
        end else if (a == 56) begin
            mVol = d & 15;
        end
    endfunction

    function automatic void modelVoice(input int v);
        int unsigned acc, top, wave, fb;
        bit test, gate;
        test = ((mCtrl[v] >> 4) & 1) != 0;
        gate = (mCtrl[v] & 1) != 0;
        acc = test ? 0 : (mAcc[v] + mFreq[v]) % 32'h0100_0000;
        top = acc / 4096;
        case ((mCtrl[v] >> 2) & 3)
            0: wave = top;
            1: wave = (top < 2048) ? top * 2 : (4095 - top) * 2;
            2: wave = (top >= mPw[v]) ? 4095 : 0;
            default: begin
`ifdef SID_VOICE_NOISE_EN
                wave = (mLfsr[v] / 16) * 2;
`else
                wave = 0;
`endif
            end
        endcase
        mMix = mMix + (wave * mLevel[v]) / 256;
        if (mRatectr[v] == mRate[v]) begin
            mRatectr[v] = 0;
            if (gate && mLevel[v] < 255) mLevel[v]++;
            if (!gate && mLevel[v] > 0) mLevel[v]--;
        end else begin
            mRatectr[v] = (mRatectr[v] + 1) % 256;
        end
        if (test) begin
            mLfsr[v] = 32'h7FFF;
        end else if (((mAcc[v] >> 19) & 1) == 0 && ((acc >> 19) & 1) == 1) begin
            fb = ((mLfsr[v] >> 14) ^ (mLfsr[v] >> 13)) & 1;
            mLfsr[v] = ((mLfsr[v] * 2) | fb) & 32'h7FFF;
        end
        mAcc[v] = acc;
    endfunction

    // One clock of bus activity; the model predicts what this clock's edge produces
    task automatic applyStimulus(input bit cyc, input bit we, input int a, input int d);
        int slot;
        addr = 6'(a); bus_in = 8'(d); bus_cyc = cyc; bus_we = we;
        slot = cycleN % (V + 1);
        if (cyc) expRead.push_back(readModel(a));
        if (slot < V) begin
            modelVoice(slot);
        end else begin
            if (checkSamples) expSample.push_back(int'((mMix * mVol) / 16));
            mMix = 0;
        end
        if (cyc && we) writeModel(a, d);
        cycleN++;
        @(posedge clk); #1;
        bus_cyc = 1'b0; bus_we = 1'b0;
    endtask

    task automatic randomCycle(input int writePct, input int readPct);
        int r, a;
        r = $urandom_range(0, 99);
        a = $urandom_range(0, 63);
        if (a == 57) a = 56;
        if (r < writePct) applyStimulus(1, 1, a, $urandom_range(0, 255));
        else if (r < writePct + readPct) applyStimulus(1, 0, a, 0);
        else applyStimulus(0, 0, 0, 0);
    endtask

    task automatic rawWrite(input int a, input int d, input int preValue);
        addr = 6'(a); bus_in = 8'(d); bus_cyc = 1'b1; bus_we = 1'b1;
        expRead.push_back(preValue);
        @(posedge clk); #1;
        bus_cyc = 1'b0; bus_we = 1'b0;
    endtask

    task automatic waitStrobe(input string name, output int cycles);
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cycles++;
            if (sample_ready === 1'b1) return;
        end
        checks++; failures++;
        $display("[TB] FAIL %s strobe timeout actual=none required=strobe", name);
    endtask

    task automatic doReset();
        rst = 1'b1; bus_cyc = 1'b0; bus_we = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
    endtask

    task automatic drain();
        @(negedge clk); #1;
        checkOutput("sample_queue_left", expSample.size(), 0);
        checkOutput("read_queue_left", expRead.size(), 0);
        checkSamples = 1'b0;
    endtask

    always @(posedge clk) rdValid <= bus_cyc && !rst;

    // Monitor: compares whatever the DUT presents against the oldest queued expectation
    always @(negedge clk) begin
        if (checkSamples && sample_ready === 1'b1) begin
            if (expSample.size() == 0) begin
                checks++; failures++;
                $display("[TB] FAIL sample_extra actual=0x%0h required=no strobe", sample_out);
            end else begin
                checkOutput("sample", sample_out, expSample.pop_front());
            end
        end
        if (rdValid) begin
            if (expRead.size() == 0) begin
                checks++; failures++;
                $display("[TB] FAIL read_extra actual=0x%0h required=no read", bus_out);
            end else begin
                checkOutput("bus_read", bus_out, expRead.pop_front());
            end
        end
    end

    initial begin
        int period, strobes;
        doReset();
        checkOutput("reset_bus_out", bus_out, 0);
        checkOutput("reset_sample_out", sample_out, 0);
        checkOutput("reset_sample_ready", sample_ready, 0);
        checkSamples = 1'b1;
        applyStimulus(1, 0, 3, 0);
        applyStimulus(1, 0, 4, 0);
        applyStimulus(1, 0, 59, 0);

        $display("[TB] random traffic");
        repeat (3000) randomCycle(15, 15);

        $display("[TB] attack to saturation");
        for (int v = 0; v < V; v++) begin
            applyStimulus(1, 1, v * 8 + 5, 1 | ($urandom_range(0, 2) << 2));
            applyStimulus(1, 1, v * 8 + 6, 0);
        end
        applyStimulus(1, 1, 56, 15);
        repeat (1400) randomCycle(0, 20);
        for (int v = 0; v < V; v++) applyStimulus(1, 0, v * 8 + 7, 0);

        $display("[TB] release to zero");
        for (int v = 0; v < V; v++) begin
            applyStimulus(1, 1, v * 8 + 6, 3);
            applyStimulus(1, 1, v * 8 + 5, $urandom_range(0, 2) << 2);
        end
        repeat (5300) randomCycle(0, 10);
        for (int v = 0; v < V; v++) applyStimulus(1, 0, v * 8 + 7, 0);
        drain();

        $display("[TB] clock divider");
        rawWrite(57, 3, 0);
        waitStrobe("div3_a", period);
        waitStrobe("div3_b", period);
        waitStrobe("div3_c", period);
        checkOutput("div3_period", period, 4 * (V + 1));
        @(negedge clk);
        checkOutput("strobe_width", sample_ready, 0);
        @(posedge clk); #1;
        rawWrite(57, 0, 3);
        waitStrobe("div0_a", period);
        waitStrobe("div0_b", period);
        checkOutput("div0_period", period, V + 1);

        $display("[TB] reset mid-frame");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sample_ready === 1'b1) strobes++;
        end
        checkOutput("reset_no_strobe", strobes, 0);
        checkOutput("reset2_sample_out", sample_out, 0);
        checkOutput("reset2_bus_out", bus_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        modelReset();
        checkSamples = 1'b1;
        applyStimulus(1, 0, 59, 0);
        applyStimulus(1, 0, 4, 0);
        applyStimulus(1, 1, 0, 8'h00);
        applyStimulus(1, 1, 1, 8'h10);
        applyStimulus(1, 1, 5, 8'h01);
        applyStimulus(1, 1, 56, 8'h0F);
        repeat (60) randomCycle(0, 20);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
